axi_rd_arbiter: RTL and testbench

//  Shares the single AXI read channel (AR/R) between three requesters: ICache refill (0), DCache refill (1), uncached load (2).

---
 rtl/axi_rd_arbiter.sv | 166 ++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - three-requester AXI read-channel arbiter with burst-length checking
// Optional round-robin arbitration when AXI_RD_RR_EN is defined; fixed priority 1>2>0 otherwise.
module axi_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [2:0]          req_arvalid,
    input  logic [3*ADDR_W-1:0] req_araddr,
    input  logic [3*LEN_W-1:0]  req_arlen,
    input  logic [8:0]          req_arsize,
    output logic [2:0]          req_arready,
    output logic [2:0]          req_rvalid,
    output logic [DATA_W-1:0]   req_rdata,
    output logic                req_rlast,
    input  logic [2:0]          req_rready,
    output logic                m_arvalid,
    output logic [3:0]          m_arid,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic [LEN_W-1:0]    m_arlen,
    output logic [2:0]          m_arsize,
    input  logic                m_arready,
    input  logic                m_rvalid,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_rlast,
    output logic                m_rready,
    output logic [1:0]          grant,
    output logic                busy,
    output logic                rd_err
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

    state_t            state_q, state_d;
    logic [1:0]        grant_q;
    logic [1:0]        win;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [2:0]        size_q;
    logic [LEN_W:0]    count_q;
    logic              err_q;
    logic              ar_hs;
    logic              r_hs;
    logic              last_expected;

    function automatic logic [1:0] pick(input logic [2:0] v, input logic [1:0] a,
                                        input logic [1:0] b, input logic [1:0] c);
        if (v[a]) return a;
        if (v[b]) return b;
        return c;
    endfunction

`ifdef AXI_RD_RR_EN
    logic [1:0] last_grant_q;

    // Search starts just after the previous winner so every requester gets a turn.
    always_comb begin
        case (last_grant_q)
            2'd0:    win = pick(req_arvalid, 2'd1, 2'd2, 2'd0);
            2'd1:    win = pick(req_arvalid, 2'd2, 2'd0, 2'd1);
            default: win = pick(req_arvalid, 2'd0, 2'd1, 2'd2);
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_grant_q <= 2'd2;
        end else if (ar_hs) begin
            last_grant_q <= grant_q;
        end
    end
`else
    always_comb begin
        win = pick(req_arvalid, 2'd1, 2'd2, 2'd0);
    end
`endif

    assign ar_hs         = (state_q == S_ADDR) && m_arready;
    assign r_hs          = (state_q == S_DATA) && m_rvalid && m_rready;
    assign last_expected = (count_q == {1'b0, len_q});

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (|req_arvalid) state_d = S_ADDR;
            S_ADDR:  if (m_arready) state_d = S_DATA;
            S_DATA:  if (r_hs && m_rlast) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_arready = 3'b000;
        req_rvalid  = 3'b000;
        req_rdata   = '0;
        req_rlast   = 1'b0;
        m_arvalid   = 1'b0;
        m_rready    = 1'b0;
        case (state_q)
            S_ADDR: begin
                m_arvalid            = 1'b1;
                req_arready[grant_q] = m_arready;
            end
            S_DATA: begin
                req_rvalid[grant_q] = m_rvalid;
                m_rready            = req_rready[grant_q];
                req_rdata           = m_rdata;
                req_rlast           = m_rlast;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            grant_q <= 2'd0;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= 3'd0;
        end else if (state_q == S_IDLE && |req_arvalid) begin
            grant_q <= win;
            addr_q  <= req_araddr[win*ADDR_W +: ADDR_W];
            len_q   <= req_arlen[win*LEN_W +: LEN_W];
            size_q  <= req_arsize[win*3 +: 3];
        end
    end

    // Beat index of the burst in flight; saturates rather than wrapping so an
    // overlong burst keeps reporting the missing rlast.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else if (ar_hs) begin
            count_q <= '0;
        end else if (r_hs && count_q != '1) begin
            count_q <= count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_q <= 1'b0;
        end else if (r_hs && (m_rlast != last_expected)) begin
            err_q <= 1'b1;
        end
    end

    assign m_arid   = {2'b00, grant_q};
    assign m_araddr = addr_q;
    assign m_arlen  = len_q;
    assign m_arsize = size_q;
    assign grant    = grant_q;
    assign busy     = (state_q != S_IDLE);
    assign rd_err   = err_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - directed scoreboard bench for axi_rd_arbiter
module tb_axi_rd_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic [2:0]  req_arvalid;
    logic [95:0] req_araddr;
    logic [23:0] req_arlen;
    logic [8:0]  req_arsize;
    logic [2:0]  req_arready;
    logic [2:0]  req_rvalid;
    logic [31:0] req_rdata;
    logic        req_rlast;
    logic [2:0]  req_rready;
    logic        m_arvalid;
    logic [3:0]  m_arid;
    logic [31:0] m_araddr;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic        m_arready;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    logic        m_rlast;
    logic        m_rready;
    logic [1:0]  grant;
    logic        busy;
    logic        rd_err;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] tb_addr [3];
    int          tb_len  [3];
    logic [32:0] sb [$];

    axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .LEN_W(8)) dut (
        .clk(clk), .resetn(resetn),
        .req_arvalid(req_arvalid), .req_araddr(req_araddr), .req_arlen(req_arlen),
        .req_arsize(req_arsize), .req_arready(req_arready),
        .req_rvalid(req_rvalid), .req_rdata(req_rdata), .req_rlast(req_rlast),
        .req_rready(req_rready),
        .m_arvalid(m_arvalid), .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arsize(m_arsize), .m_arready(m_arready),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rready(m_rready),
        .grant(grant), .busy(busy), .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] addr, input int len);
        req_araddr[i*32 +: 32] = addr;
        req_arlen[i*8 +: 8]    = 8'(len);
        req_arsize[i*3 +: 3]   = 3'd2;
        req_arvalid[i]         = 1'b1;
        tb_addr[i]             = addr;
        tb_len[i]              = len;
    endtask

    // Entered and left on a falling edge with the DUT idle; abort_at >= 0 returns
    // with that beat on the bus and the burst still open.
    task automatic run_burst(input int g, input int ar_delay, input int rlast_at,
                             input bit toggle, input int abort_at);
        logic [31:0] d;
        logic [32:0] e;
        logic [2:0]  oh;
        bit          hs;
        int          last_beat;
        int          ph;
        oh = 3'(1 << g);
        #1;
        check("idle_arvalid", m_arvalid, 0);
        @(posedge clk); @(negedge clk); #1;
        check("arvalid", m_arvalid, 1);
        check("grant", grant, g);
        check("arid", m_arid, {2'b00, 2'(g)});
        check("araddr", m_araddr, tb_addr[g]);
        check("arlen", m_arlen, tb_len[g]);
        check("arsize", m_arsize, 2);
        for (int i = 0; i < ar_delay; i++) begin
            m_arready = 1'b0;
            @(posedge clk); @(negedge clk); #1;
            check("ar_hold_valid", m_arvalid, 1);
            check("ar_hold_addr", m_araddr, tb_addr[g]);
            check("ar_hold_len", m_arlen, tb_len[g]);
            check("ar_hold_ready", req_arready, 0);
        end
        m_arready = 1'b1;
        #1;
        check("arready_pulse", req_arready, oh);
        @(posedge clk); @(negedge clk);
        m_arready      = 1'b0;
        req_arvalid[g] = 1'b0;
        #1;
        check("arready_done", req_arready, 0);
        check("busy_data", busy, 1);
        last_beat = (rlast_at < 0) ? tb_len[g] : rlast_at;
        ph = 0;
        for (int b = 0; b <= last_beat; b++) begin
            d        = $urandom;
            m_rvalid = 1'b1;
            m_rdata  = d;
            m_rlast  = (b == last_beat);
            if (b == abort_at) begin
                req_rready = 3'b111;
                return;
            end
            sb.push_back({m_rlast, d});
            do begin
                req_rready = (!toggle || ph % 2 == 0) ? 3'b111 : ~oh;
                #1;
                check("m_rready", m_rready, req_rready[g]);
                check("rvalid_route", req_rvalid, oh);
                hs = m_rready;
                if (hs) begin
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check("rbeat", {req_rlast, req_rdata}, e);
                    end else begin
                        check("sb_underflow", sb.size(), 1);
                    end
                end
                ph++;
                @(posedge clk); @(negedge clk);
            end while (!hs);
        end
        m_rvalid   = 1'b0;
        m_rlast    = 1'b0;
        req_rready = 3'b000;
        #1;
        check("idle_after", busy, 0);
        check("rready_idle", m_rready, 0);
    endtask

    initial begin
        resetn      = 1'b0;
        req_arvalid = 3'b000;
        req_araddr  = '0;
        req_arlen   = '0;
        req_arsize  = '0;
        req_rready  = 3'b000;
        m_arready   = 1'b0;
        m_rvalid    = 1'b0;
        m_rdata     = '0;
        m_rlast     = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_grant", grant, 0);
        check("rst_arvalid", m_arvalid, 0);
        check("rst_rready", m_rready, 0);
        check("rst_err", rd_err, 0);
        check("rst_arready", req_arready, 0);
        check("rst_rvalid", req_rvalid, 0);
        resetn = 1'b1;
        @(negedge clk);

        // T2 first so the round-robin pointer is still at its reset value
        set_req(0, 32'h0000_1000, 3);
        set_req(1, 32'h0000_2000, 1);
        set_req(2, 32'h0000_3000, 0);
`ifdef AXI_RD_RR_EN
        run_burst(0, 0, -1, 1'b0, -1);
        run_burst(1, 0, -1, 1'b0, -1);
        run_burst(2, 0, -1, 1'b0, -1);
`else
        run_burst(1, 0, -1, 1'b0, -1);
        run_burst(2, 0, -1, 1'b0, -1);
        run_burst(0, 0, -1, 1'b0, -1);
`endif

        // T1
        set_req(0, 32'h1FC0_0000, 7);
        run_burst(0, 0, -1, 1'b0, -1);
        check("t1_err", rd_err, 0);

        // T3
        set_req(2, 32'h8000_0040, 3);
        run_burst(2, 5, -1, 1'b0, -1);

        // T4
        set_req(1, 32'h0000_4000, 3);
        run_burst(1, 0, -1, 1'b1, -1);
        check("t4_err", rd_err, 0);

        // T5
        set_req(0, 32'h0000_5000, 3);
        run_burst(0, 0, 2, 1'b0, -1);
        check("t5_err", rd_err, 1);
        set_req(1, 32'h0000_6000, 2);
        run_burst(1, 1, -1, 1'b0, -1);
        check("t5_err_sticky", rd_err, 1);

        // T6
        set_req(0, 32'h0000_7000, 7);
        run_burst(0, 0, -1, 1'b0, 2);
        #2 resetn = 1'b0;
        #1;
        check("t6_busy", busy, 0);
        check("t6_arvalid", m_arvalid, 0);
        check("t6_rready", m_rready, 0);
        check("t6_rvalid", req_rvalid, 0);
        check("t6_grant", grant, 0);
        check("t6_err", rd_err, 0);
        check("t6_rdata", req_rdata, 0);
        sb.delete();
        m_rvalid    = 1'b0;
        m_rlast     = 1'b0;
        req_rready  = 3'b000;
        req_arvalid = 3'b000;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        set_req(2, 32'h0000_9000, 0);
        run_burst(2, 0, -1, 1'b0, -1);
        check("t6_err_after", rd_err, 0);

        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
